// File: rtl/key_sw_io.sv
// key_sw_io: memory-mapped push-button / slide-switch input device.
// Two-flop synchronizers, per-group debounce, ready/overrun status per group.
// Optional build macro KEY_SW_IO_IRQ_EN adds a registered irq output and the
// read/write ie bit (bit8) in each control register.
module key_sw_io #(
  parameter int unsigned      DBITS           = 32,
  parameter int unsigned      KEY_BITS        = 4,
  parameter int unsigned      SW_BITS         = 10,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000,
  parameter int unsigned      CNT_BITS        = 20,
  parameter logic [DBITS-1:0] ADDR_KDATA      = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SDATA      = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_KCTRL      = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDR_SCTRL      = 32'hF0000114
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [KEY_BITS-1:0] key_n,
  input  logic [SW_BITS-1:0]  sw,
  input  logic [DBITS-1:0]    addr,
  input  logic                re,
  input  logic                we,
  input  logic [DBITS-1:0]    wdata,
`ifdef KEY_SW_IO_IRQ_EN
  output logic                irq,
`endif
  output logic [DBITS-1:0]    rdata,
  output logic                sel
);

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE_CYCLES - 1);

  // Synchronizer and previous-sample stages (key path stored as 1 = pressed)
  logic [KEY_BITS-1:0] key_s1, key_s2, key_prev, key_deb;
  logic [SW_BITS-1:0]  sw_s1, sw_s2, sw_prev, sw_deb;
  logic [CNT_BITS-1:0] key_cnt, sw_cnt;

  // Status bits
  logic key_ready, key_ovr, sw_ready, sw_ovr;
`ifdef KEY_SW_IO_IRQ_EN
  logic key_ie, sw_ie;
`endif

  // Address decode and per-register strobes
  logic hit_kdata, hit_sdata, hit_kctrl, hit_sctrl;
  logic key_inc, sw_inc, key_upd, sw_upd;
  logic key_rd_clr, sw_rd_clr, kctrl_wr, sctrl_wr;
  logic unused_wdata;

  assign hit_kdata = (addr == ADDR_KDATA);
  assign hit_sdata = (addr == ADDR_SDATA);
  assign hit_kctrl = (addr == ADDR_KCTRL);
  assign hit_sctrl = (addr == ADDR_SCTRL);
  assign sel       = hit_kdata | hit_sdata | hit_kctrl | hit_sctrl;

  // Count only while the synchronized value is stable and differs from deb
  assign key_inc = (key_s2 == key_prev) && (key_s2 != key_deb);
  assign sw_inc  = (sw_s2 == sw_prev) && (sw_s2 != sw_deb);
  assign key_upd = key_inc && (key_cnt == CNT_LAST);
  assign sw_upd  = sw_inc && (sw_cnt == CNT_LAST);

  assign key_rd_clr = re & hit_kdata;
  assign sw_rd_clr  = re & hit_sdata;
  assign kctrl_wr   = we & hit_kctrl;
  assign sctrl_wr   = we & hit_sctrl;

  // Only bits 2 and 8 of wdata are meaningful
  assign unused_wdata = ^wdata;

  // Combinational read mux; unmapped addresses read zero
  always_comb begin
    rdata = '0;
    if (hit_kdata) begin
      rdata = DBITS'(key_deb);
    end else if (hit_sdata) begin
      rdata = DBITS'(sw_deb);
    end else if (hit_kctrl) begin
      rdata[0] = key_ready;
      rdata[2] = key_ovr;
`ifdef KEY_SW_IO_IRQ_EN
      rdata[8] = key_ie;
`endif
    end else if (hit_sctrl) begin
      rdata[0] = sw_ready;
      rdata[2] = sw_ovr;
`ifdef KEY_SW_IO_IRQ_EN
      rdata[8] = sw_ie;
`endif
    end
  end

  // Synchronizers and debounce counters for both groups
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1   <= '0;
      key_s2   <= '0;
      key_prev <= '0;
      key_deb  <= '0;
      key_cnt  <= '0;
      sw_s1    <= '0;
      sw_s2    <= '0;
      sw_prev  <= '0;
      sw_deb   <= '0;
      sw_cnt   <= '0;
    end else begin
      key_s1   <= ~key_n;
      key_s2   <= key_s1;
      key_prev <= key_s2;
      sw_s1    <= sw;
      sw_s2    <= sw_s1;
      sw_prev  <= sw_s2;

      if (key_upd) begin
        key_deb <= key_s2;
        key_cnt <= '0;
      end else if (key_inc) begin
        key_cnt <= key_cnt + CNT_BITS'(1);
      end else begin
        key_cnt <= '0;
      end

      if (sw_upd) begin
        sw_deb <= sw_s2;
        sw_cnt <= '0;
      end else if (sw_inc) begin
        sw_cnt <= sw_cnt + CNT_BITS'(1);
      end else begin
        sw_cnt <= '0;
      end
    end
  end

  // Ready/overrun status; a new update beats a clearing read or write
  always_ff @(posedge clk) begin
    if (reset) begin
      key_ready <= 1'b0;
      key_ovr   <= 1'b0;
      sw_ready  <= 1'b0;
      sw_ovr    <= 1'b0;
    end else begin
      if (key_upd)         key_ready <= 1'b1;
      else if (key_rd_clr) key_ready <= 1'b0;

      if (key_upd && key_ready && !key_rd_clr) key_ovr <= 1'b1;
      else if (kctrl_wr && !wdata[2])          key_ovr <= 1'b0;

      if (sw_upd)         sw_ready <= 1'b1;
      else if (sw_rd_clr) sw_ready <= 1'b0;

      if (sw_upd && sw_ready && !sw_rd_clr) sw_ovr <= 1'b1;
      else if (sctrl_wr && !wdata[2])       sw_ovr <= 1'b0;
    end
  end

`ifdef KEY_SW_IO_IRQ_EN
  // Interrupt enables and registered interrupt request
  always_ff @(posedge clk) begin
    if (reset) begin
      key_ie <= 1'b0;
      sw_ie  <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (kctrl_wr) key_ie <= wdata[8];
      if (sctrl_wr) sw_ie  <= wdata[8];
      irq <= (key_ready & key_ie) | (sw_ready & sw_ie);
    end
  end
`endif

endmodule
